laser_line_locator: RTL

Consumes the blurred pixel stream from the blur stage (8-bit luma with fvh/dv framing). For each active video row it finds the column of the brightest contiguous plateau, the laser stripe, and emits one result per row (row, centre column, peak value, found flag) on a valid/ready port. The depth-reconstruction logic consumes those results.

---
 rtl/scanner_pkg.sv | 17 +
 rtl/fvh_edge_detect.sv | 31 +++
 rtl/laser_line_locator.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/scanner_pkg.sv
// Shared definitions for the scanner video pipeline: FSM states, fvh bit
// positions and the default active width used by the blur and locator stages.
package scanner_pkg;

  typedef enum logic [1:0] {
    SYNC,
    VBLANK,
    LINE
  } scan_state_t;

  localparam int unsigned FVH_F = 2;
  localparam int unsigned FVH_V = 1;
  localparam int unsigned FVH_H = 0;

  localparam int unsigned DEFAULT_IMG_WIDTH = 859;

endpackage

// File: rtl/fvh_edge_detect.sv
// Registers the fvh framing flags and reports vertical rise/fall and
// horizontal rise events relative to the previous cycle.
module fvh_edge_detect
  import scanner_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] fvh_in,
  output logic       v_rise,
  output logic       v_fall,
  output logic       h_rise
);

  logic [2:0] fvh_prev;
  logic       unused_field;

  // Reset value assumes blanking so a stream starting mid-blank gives no edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fvh_prev <= 3'b011;
    end else begin
      fvh_prev <= fvh_in;
    end
  end

  assign v_rise       =  fvh_in[FVH_V] & ~fvh_prev[FVH_V];
  assign v_fall       = ~fvh_in[FVH_V] &  fvh_prev[FVH_V];
  assign h_rise       =  fvh_in[FVH_H] & ~fvh_prev[FVH_H];
  assign unused_field =  fvh_prev[FVH_F];

endmodule

// File: rtl/laser_line_locator.sv
// Finds the brightest contiguous plateau (laser stripe) in each active row
// and offers {row, centre column, peak, found} on a one-deep valid/ready slot.
module laser_line_locator
  import scanner_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = DEFAULT_IMG_WIDTH,
  parameter int unsigned COL_BITS  = 10,
  parameter int unsigned ROW_BITS  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          px_in,
  input  logic [2:0]          fvh_in,
  input  logic                dv_in,
  input  logic [7:0]          threshold,
  output logic [ROW_BITS-1:0] result_row,
  output logic [COL_BITS-1:0] result_col,
  output logic [7:0]          result_peak,
  output logic                result_found,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                overflow,
  output logic                frame_done
);

  localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(IMG_WIDTH);

  scan_state_t         state_q, state_d;
  logic                v_rise, v_fall, h_rise;
  logic [COL_BITS-1:0] col_q;
  logic [ROW_BITS-1:0] row_q;
  logic [7:0]          best_q;
  logic [COL_BITS-1:0] first_q, last_q;
  logic [7:0]          thr_q;

  logic                accept, track, row_end, frame_start, consume, load;
  logic [COL_BITS:0]   last_inc, centre_sum;
  logic [COL_BITS-1:0] centre;
  logic                found;

  fvh_edge_detect u_edges (
    .clk    (clk),
    .reset  (reset),
    .fvh_in (fvh_in),
    .v_rise (v_rise),
    .v_fall (v_fall),
    .h_rise (h_rise)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNC:    if (v_rise) state_d = VBLANK;
      VBLANK:  if (v_fall) state_d = LINE;
      LINE:    if (v_rise) state_d = VBLANK;
      default: state_d = SYNC;
    endcase
  end

  // v_rise wins over a coincident h_rise: the row in progress is dropped.
  assign frame_start = (state_q == VBLANK) && v_fall;
  assign accept      = (state_q == LINE) && dv_in && (fvh_in[FVH_V:FVH_H] == 2'b00);
  assign track       = accept && (col_q != COL_MAX);
  assign row_end     = (state_q == LINE) && h_rise && !v_rise && (col_q != '0);
  assign consume     = result_valid && result_ready;
  assign load        = row_end && (!result_valid || result_ready);

  assign last_inc   = {1'b0, last_q} + (COL_BITS + 1)'(1);
  assign centre_sum = {1'b0, first_q} + {1'b0, last_q};
  assign centre     = centre_sum[COL_BITS:1];
  assign found      = (best_q >= thr_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q   <= '0;
      row_q   <= '0;
      best_q  <= '0;
      first_q <= '0;
      last_q  <= '0;
      thr_q   <= '0;
    end else if (frame_start) begin
      col_q   <= '0;
      row_q   <= '0;
      best_q  <= '0;
      first_q <= '0;
      last_q  <= '0;
      thr_q   <= threshold;
    end else if (row_end) begin
      col_q   <= '0;
      row_q   <= row_q + 1'b1;
      best_q  <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else if (track) begin
      col_q <= col_q + 1'b1;
      if (px_in > best_q) begin
        best_q  <= px_in;
        first_q <= col_q;
        last_q  <= col_q;
      end else if (px_in == best_q && {1'b0, col_q} == last_inc) begin
        last_q <= col_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_row   <= '0;
      result_col   <= '0;
      result_peak  <= '0;
      result_found <= 1'b0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= (state_q == LINE) && v_rise;
      if (frame_start) begin
        overflow <= 1'b0;
      end else if (row_end && !load) begin
        overflow <= 1'b1;
      end
      if (load) begin
        result_row   <= row_q;
        result_col   <= found ? centre : '0;
        result_peak  <= best_q;
        result_found <= found;
        result_valid <= 1'b1;
      end else if (consume) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule
